xy_stimulus_gen: RTL and testbench

- Transmit-side counterpart of the team's two-input x/y sequence detector.
- Drives out_x/out_y so that the detector (z = 1 in states S2/S3) raises z for exactly a requested number of cycles, then returns to S0.
- Lets the detector be exercised on the board and in system sims from a single start command, instead of hand-toggled switches.
- Both reach paths are supported: fast (S0->S3 via x=1,y=0) and slow (S0->S1->S2->S3 via x=1,y=1 first).

---
 rtl/xy_stimulus_gen.sv | 116 +++++++++++
 tb/tb_xy_stimulus_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/xy_stimulus_gen.sv
// Stimulus generator for the two-input x/y sequence detector: drives x/y so the
// detector holds z high for in_len cycles. Optional looping is built with XYGEN_LOOP_EN.
module xy_stimulus_gen #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_start,
  input  logic             in_fast,
  input  logic [LEN_W-1:0] in_len,
`ifdef XYGEN_LOOP_EN
  input  logic             in_loop,
`endif
  output logic             out_x,
  output logic             out_y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LEAD, ASSERT, RELEASE} state_t;

  typedef struct packed {
    logic x;
    logic y;
    logic busy;
    logic done;
  } outs_t;

  // Output pattern of each state; registered alongside the state so the
  // outputs are glitch-free and change exactly when the state does.
  function automatic outs_t decode(input state_t s);
    case (s)
      LEAD:    decode = outs_t'(4'b1110);
      ASSERT:  decode = outs_t'(4'b1010);
      RELEASE: decode = outs_t'(4'b0011);
      default: decode = outs_t'(4'b0000);
    endcase
  endfunction

  state_t           state;
  logic [LEN_W-1:0] cnt;
  outs_t            outs;
`ifdef XYGEN_LOOP_EN
  logic [LEN_W-1:0] len_q;
  logic             fast_q;
`endif

  assign {out_x, out_y, busy, done} = outs;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state  <= IDLE;
      cnt    <= '0;
      outs   <= decode(IDLE);
`ifdef XYGEN_LOOP_EN
      len_q  <= '0;
      fast_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_start && (in_len != '0)) begin
            cnt <= in_len;
`ifdef XYGEN_LOOP_EN
            len_q  <= in_len;
            fast_q <= in_fast;
`endif
            if (in_fast) begin
              state <= ASSERT;
              outs  <= decode(ASSERT);
            end else begin
              state <= LEAD;
              outs  <= decode(LEAD);
            end
          end
        end
        LEAD: begin
          state <= ASSERT;
          outs  <= decode(ASSERT);
        end
        ASSERT: begin
          // Leaving on a count of 1 keeps the counter from ever reaching zero here.
          if (cnt == LEN_W'(1)) begin
            state <= RELEASE;
            outs  <= decode(RELEASE);
          end else begin
            cnt <= cnt - LEN_W'(1);
          end
        end
        RELEASE: begin
`ifdef XYGEN_LOOP_EN
          if (in_loop) begin
            cnt <= len_q;
            if (fast_q) begin
              state <= ASSERT;
              outs  <= decode(ASSERT);
            end else begin
              state <= LEAD;
              outs  <= decode(LEAD);
            end
          end else begin
            state <= IDLE;
            outs  <= decode(IDLE);
          end
`else
          state <= IDLE;
          outs  <= decode(IDLE);
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xy_stimulus_gen.sv
// Self-checking bench for xy_stimulus_gen: a per-cycle expected-output queue model,
// directed literal checks, and a randomized phase. Loop tests run when XYGEN_LOOP_EN is set.
module tb_xy_stimulus_gen;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset_b;
  logic             in_start;
  logic             in_fast;
  logic [LEN_W-1:0] in_len;
  logic             in_loop;
  logic             out_x, out_y, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xy_stimulus_gen #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .in_start (in_start),
    .in_fast  (in_fast),
    .in_len   (in_len),
`ifdef XYGEN_LOOP_EN
    .in_loop  (in_loop),
`endif
    .out_x    (out_x),
    .out_y    (out_y),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted start queues the whole per-cycle output sequence
  // {x,y,busy,done}; an empty queue means idle (all zero).
  logic [3:0]       q[$];
  logic [3:0]       exp_cur;
  logic [LEN_W-1:0] m_len;
  logic             m_fast;

  task automatic push_seq(input int len, input bit fast);
    if (!fast) q.push_back(4'b1110);
    for (int i = 0; i < len; i++) q.push_back(4'b1010);
    q.push_back(4'b0011);
  endtask

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      q.delete();
      exp_cur <= 4'b0000;
      m_len   <= '0;
      m_fast  <= 1'b0;
    end else begin
      if (!exp_cur[1] && in_start && in_len != 0) begin
        push_seq(int'(in_len), in_fast);
        m_len  <= in_len;
        m_fast <= in_fast;
      end
`ifdef XYGEN_LOOP_EN
      if (exp_cur[0] && in_loop) push_seq(int'(m_len), m_fast);
`endif
      exp_cur <= (q.size() != 0) ? q.pop_front() : 4'b0000;
    end
  end

  always @(negedge clk) begin
    check("x", out_x, exp_cur[3]);
    check("y", out_y, exp_cur[2]);
    check("busy", busy, exp_cur[1]);
    check("done", done, exp_cur[0]);
  end

  // Busy-run length and done-pulse monitor.
  int run = 0, last_run = 0, done_count = 0;
  always @(negedge clk) begin
    if (busy) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic start(input int len, input bit fast);
    @(posedge clk); #1;
    in_start = 1'b1; in_len = LEN_W'(len); in_fast = fast;
    @(posedge clk); #1;
    in_start = 1'b0;
  endtask

  task automatic capture(input int n, output logic [15:0] xy, output logic [7:0] b, output logic [7:0] d);
    xy = '0; b = '0; d = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      xy = {xy[13:0], out_x, out_y};
      b  = {b[6:0], busy};
      d  = {d[6:0], done};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] xy;
    logic [7:0]  b, d;
    int d0, k;

    reset_b = 1'b0; in_start = 1'b0; in_fast = 1'b0; in_len = '0; in_loop = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_b = 1'b1;

    // Idle after reset
    capture(5, xy, b, d);
    check("idle_xy", xy, 16'h0000);
    check("idle_busy", b, 8'h00);
    check("idle_done", d, 8'h00);

    // Fast L=3: 10,10,10,00 then idle
    d0 = done_count;
    start(3, 1'b1);
    capture(5, xy, b, d);
    check("fast3_xy", xy, 16'b10_10_10_00_00);
    check("fast3_busy", b, 8'b11110);
    check("fast3_done", d, 8'b00010);
    @(posedge clk);
    check("fast3_run", last_run, 4);
    check("fast3_ndone", done_count - d0, 1);

    // Slow L=2: 11,10,10,00
    start(2, 1'b0);
    capture(5, xy, b, d);
    check("slow2_xy", xy, 16'b11_10_10_00_00);
    check("slow2_busy", b, 8'b11110);
    check("slow2_done", d, 8'b00010);

    // Zero length is ignored
    d0 = done_count;
    start(0, 1'b1);
    capture(3, xy, b, d);
    check("len0_busy", b, 8'h00);
    check("len0_xy", xy, 16'h0000);
    @(posedge clk);
    check("len0_ndone", done_count - d0, 0);

    // Start mid-ASSERT of an L=5 run has no effect
    d0 = done_count;
    start(5, 1'b1);
    @(posedge clk); #1;
    in_start = 1'b1; in_len = 4'd3; in_fast = 1'b0;
    @(posedge clk); #1;
    in_start = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_start_run", last_run, 6);
    check("mid_start_ndone", done_count - d0, 1);

    // Async reset mid-ASSERT of L=15
    d0 = done_count;
    start(15, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("pre_rst_x", out_x, 1'b1);
    reset_b = 1'b0;
    #1;
    check("rst_x", out_x, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk); #2 reset_b = 1'b1;
    check("rst_ndone", done_count - d0, 0);
    start(1, 1'b1);
    capture(3, xy, b, d);
    check("l1_xy", xy, 16'b10_00_00);
    check("l1_busy", b, 8'b110);
    check("l1_done", d, 8'b010);

`ifdef XYGEN_LOOP_EN
    // Loop: fast L=2, loop for two RELEASEs then stop
    d0 = done_count;
    k = 0;
    in_loop = 1'b1;
    start(2, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) k++;
      if (k == 2) break;
    end
    check("loop_reach", k, 2);
    @(posedge clk); #1;
    in_loop = 1'b0;
    repeat (10) @(negedge clk);
    check("loop_run", last_run, 9);
    check("loop_ndone", done_count - d0, 3);
`endif

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      in_start = ($urandom_range(0, 2) == 0);
      in_fast  = $urandom_range(0, 1);
      in_len   = LEN_W'($urandom_range(0, 15));
      in_loop  = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    in_start = 1'b0; in_loop = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("drain_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
